// File: rtl/lsq_pkg.sv
// Load/store queue shared types and sizing.
// Entry layout plus the head issue qualifier.
package lsq_pkg;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  typedef struct packed {
    logic        valid;
    logic        is_store;
    logic        size;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        addr_rdy;
    logic        committed;
  } lsq_entry_t;

  // Head may go to memory once its address is known and,
  // for a store, the ROB has retired it.
  function automatic logic can_issue(lsq_entry_t e);
    return e.valid && e.addr_rdy
        && (!e.is_store || e.committed);
  endfunction

endpackage

// File: rtl/lsq_ptr.sv
// Wrap-around queue pointer.
// Power-of-two depth, so the natural overflow wraps.
module lsq_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q;

  // Clear wins over increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (clr_i) begin
      ptr_q <= '0;
    end else if (inc_i) begin
      ptr_q <= ptr_q + W'(1);
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/load_store_queue.sv
// In-order load/store queue in front of dataMemory.
// Stores wait for ROB commit; one op issues per cycle.
module load_store_queue #(
  parameter int DEPTH = lsq_pkg::DEPTH,
  parameter int TAG_W = lsq_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_valid,
  input  logic             alloc_isStore,
  input  logic             alloc_storeSize,
  input  logic [31:0]      alloc_PC,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             exec_valid,
  input  logic [TAG_W-1:0] exec_tag,
  input  logic [31:0]      exec_address,
  input  logic [31:0]      exec_data,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic             flush,
  input  logic             mem_stall,
  output logic [31:0]      PC_out,
  output logic [31:0]      address,
  output logic [31:0]      dataSw,
  output logic             memRead,
  output logic             memWrite,
  output logic             storeSize,
  output logic             fromLSQ,
  output logic [TAG_W:0]   count
);

  import lsq_pkg::*;

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  lsq_entry_t ent_q [DEPTH];
  lsq_entry_t ent_d [DEPTH];
  lsq_entry_t hd;

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   cnt_q;
  logic [TAG_W:0]   cnt_d;
  logic             do_alloc;
  logic             do_issue;

  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        size_q;
  logic        rd_q;
  logic        wr_q;
  logic        fl_q;

  assign hd          = ent_q[head];
  assign alloc_ready = cnt_q < FULL;
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready && !flush;
  assign do_issue    = can_issue(hd) && !mem_stall && !flush;

  lsq_ptr #(.W(TAG_W)) u_head (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (flush),
    .inc_i (do_issue),
    .ptr_o (head)
  );

  lsq_ptr #(.W(TAG_W)) u_tail (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (flush),
    .inc_i (do_alloc),
    .ptr_o (tail)
  );

  // Entry updates: AGU, commit, retire head, then new tail.
  always_comb begin
    ent_d = ent_q;
    if (exec_valid && ent_q[exec_tag].valid) begin
      ent_d[exec_tag].addr     = exec_address;
      ent_d[exec_tag].data     = exec_data;
      ent_d[exec_tag].addr_rdy = 1'b1;
    end
    if (commit_valid && ent_q[commit_tag].valid
        && ent_q[commit_tag].is_store) begin
      ent_d[commit_tag].committed = 1'b1;
    end
    if (do_issue) begin
      ent_d[head] = '0;
    end
    if (do_alloc) begin
      ent_d[tail]          = '0;
      ent_d[tail].valid    = 1'b1;
      ent_d[tail].is_store = alloc_isStore;
      ent_d[tail].size     = alloc_storeSize;
      ent_d[tail].pc       = alloc_PC;
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i] = '0;
      end
    end
  end

  // Occupancy: alloc and issue in one cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      flush:                 cnt_d = '0;
      do_alloc && !do_issue: cnt_d = cnt_q + 1'b1;
      do_issue && !do_alloc: cnt_d = cnt_q - 1'b1;
      default:               cnt_d = cnt_q;
    endcase
  end

  // Entry storage and occupancy registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  // Issue port: controls pulse, data holds between issues.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      size_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      fl_q   <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      fl_q <= 1'b0;
      if (do_issue) begin
        pc_q   <= hd.pc;
        addr_q <= hd.addr;
        data_q <= hd.data;
        size_q <= hd.size;
        rd_q   <= !hd.is_store;
        wr_q   <= hd.is_store;
        fl_q   <= 1'b1;
      end
    end
  end

  assign PC_out    = pc_q;
  assign address   = addr_q;
  assign dataSw    = data_q;
  assign storeSize = size_q;
  assign memRead   = rd_q;
  assign memWrite  = wr_q;
  assign fromLSQ   = fl_q;
  assign count     = cnt_q;

endmodule
